// File: rtl/rvv_pkg.sv
// Shared encodings for the RVV integer lane array.
// funct6 codes, operand forms, SEW codes, VLMAX helper.
package rvv_pkg;

  localparam logic [5:0] F_VADD  = 6'b000000;
  localparam logic [5:0] F_VSUB  = 6'b000010;
  localparam logic [5:0] F_VRSUB = 6'b000011;
  localparam logic [5:0] F_VMINU = 6'b000100;
  localparam logic [5:0] F_VMIN  = 6'b000101;
  localparam logic [5:0] F_VMAXU = 6'b000110;
  localparam logic [5:0] F_VMAX  = 6'b000111;
  localparam logic [5:0] F_VAND  = 6'b001001;
  localparam logic [5:0] F_VOR   = 6'b001010;
  localparam logic [5:0] F_VXOR  = 6'b001011;

  localparam logic [2:0] OP_VV = 3'b001;
  localparam logic [2:0] OP_VX = 3'b010;
  localparam logic [2:0] OP_VI = 3'b100;

  localparam logic [2:0] SEW8  = 3'd0;
  localparam logic [2:0] SEW16 = 3'd1;
  localparam logic [2:0] SEW32 = 3'd2;
  localparam logic [2:0] SEW64 = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  function automatic int unsigned vlmax(
    input int unsigned vlen,
    input logic [2:0]  vsew
  );
    return vlen >> (32'd3 + 32'(vsew));
  endfunction

endpackage

// File: rtl/rvv_elem_alu.sv
// Single-element integer op at SEW width.
// Result is returned zero-extended to 64 bits.
module rvv_elem_alu
  import rvv_pkg::*;
(
  input  logic [2:0]  sew_i,
  input  logic [5:0]  opcode_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic [63:0] y_o
);

  logic [63:0] msk, ua, ub, sa, sb, r;
  logic        ult, slt;

  always_comb begin
    unique case (sew_i)
      SEW8: begin
        msk = 64'hFF;
        sa  = {{56{a_i[7]}}, a_i[7:0]};
        sb  = {{56{b_i[7]}}, b_i[7:0]};
      end
      SEW16: begin
        msk = 64'hFFFF;
        sa  = {{48{a_i[15]}}, a_i[15:0]};
        sb  = {{48{b_i[15]}}, b_i[15:0]};
      end
      SEW32: begin
        msk = 64'hFFFF_FFFF;
        sa  = {{32{a_i[31]}}, a_i[31:0]};
        sb  = {{32{b_i[31]}}, b_i[31:0]};
      end
      default: begin
        msk = '1;
        sa  = a_i;
        sb  = b_i;
      end
    endcase
  end

  assign ua  = a_i & msk;
  assign ub  = b_i & msk;
  assign ult = ua < ub;
  assign slt = $signed(sa) < $signed(sb);

  always_comb begin
    r = '0;
    unique case (opcode_i)
      F_VADD:  r = a_i + b_i;
      F_VSUB:  r = b_i - a_i;
      F_VRSUB: r = a_i - b_i;
      F_VMINU: r = ult ? ua : ub;
      F_VMIN:  r = slt ? sa : sb;
      F_VMAXU: r = ult ? ub : ua;
      F_VMAX:  r = slt ? sb : sa;
      F_VAND:  r = a_i & b_i;
      F_VOR:   r = a_i | b_i;
      F_VXOR:  r = a_i ^ b_i;
      default: r = '0;
    endcase
  end

  assign y_o = r & msk;

endmodule

// File: rtl/rvv_lane_array.sv
// Multi-lane RVV integer ALU: LANES elements per cycle,
// masked/tail-undisturbed merge into a vd_old-seeded result.
module rvv_lane_array
  import rvv_pkg::*;
#(
  parameter int VLEN  = 128,
  parameter int LANES = 2,
  parameter int VLW   = $clog2(VLEN/8) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [2:0]        op_type,
  input  logic [2:0]        vsew,
  input  logic [VLW-1:0]    vl,
  input  logic              vm,
  input  logic [VLEN/8-1:0] v0,
  input  logic [VLEN-1:0]   vs1,
  input  logic [VLEN-1:0]   vs2,
  input  logic [VLEN-1:0]   vd_old,
  input  logic [31:0]       rs1,
  input  logic [4:0]        imm,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [VLEN-1:0]   vd
);

  localparam int EW = VLW + $clog2(LANES) + 1;
  localparam int IW = $clog2(VLEN/8);

  state_e            state_q, state_d;
  logic [VLW-1:0]    grp_q, grp_d, n_q, n_d, g_q, g_d;
  logic [5:0]        op_q, op_d;
  logic [2:0]        typ_q, typ_d, sew_q, sew_d;
  logic              vm_q, vm_d, ill_q, ill_d;
  logic [VLEN/8-1:0] v0_q, v0_d;
  logic [VLEN-1:0]   vs1_q, vs1_d, vs2_q, vs2_d;
  logic [VLEN-1:0]   res_q, res_d, m_w;
  logic [63:0]       sc_q, sc_d, wm;

  logic              ill_now;
  logic [VLW-1:0]    n_now, g_now;
  int unsigned       vmax;

  logic [EW-1:0]     e_l  [LANES];
  logic [IW-1:0]     ei_l [LANES];
  int unsigned       sh_l [LANES];
  logic [63:0]       a_l  [LANES];
  logic [63:0]       b_l  [LANES];
  logic [63:0]       y_l  [LANES];
  logic [LANES-1:0]  en_l;

  // Decode legality and group count from the live inputs.
  always_comb begin
    ill_now = 1'b0;
    unique case (opcode)
      F_VADD, F_VMINU, F_VMIN, F_VMAXU, F_VMAX,
      F_VAND, F_VOR, F_VXOR: ill_now = 1'b0;
      F_VSUB:  ill_now = (op_type == OP_VI);
      F_VRSUB: ill_now = (op_type == OP_VV);
      default: ill_now = 1'b1;
    endcase
    if (vsew > SEW64) ill_now = 1'b1;
    if (op_type != OP_VV && op_type != OP_VX && op_type != OP_VI)
      ill_now = 1'b1;
    vmax  = vlmax(VLEN, vsew);
    n_now = (32'(vl) < vmax) ? vl : VLW'(vmax);
    g_now = VLW'((32'(n_now) + 32'(LANES) - 1) / 32'(LANES));
    if (ill_now) g_now = '0;
  end

  always_comb begin
    unique case (sew_q)
      SEW8:    wm = 64'hFF;
      SEW16:   wm = 64'hFFFF;
      SEW32:   wm = 64'hFFFF_FFFF;
      default: wm = '1;
    endcase
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      e_l[k]  = EW'(grp_q) * EW'(LANES) + EW'(k);
      ei_l[k] = e_l[k][IW-1:0];
      sh_l[k] = 32'(e_l[k]) << (32'(sew_q) + 32'd3);
      en_l[k] = (state_q == S_RUN) && (e_l[k] < EW'(n_q))
                && (vm_q || v0_q[ei_l[k]]);
      b_l[k]  = 64'(vs2_q >> sh_l[k]);
      a_l[k]  = (typ_q == OP_VV) ? 64'(vs1_q >> sh_l[k]) : sc_q;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    rvv_elem_alu u_alu (
      .sew_i    (sew_q),
      .opcode_i (op_q),
      .a_i      (a_l[k]),
      .b_i      (b_l[k]),
      .y_o      (y_l[k])
    );
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    n_d     = n_q;
    g_d     = g_q;
    op_d    = op_q;
    typ_d   = typ_q;
    sew_d   = sew_q;
    vm_d    = vm_q;
    ill_d   = ill_q;
    v0_d    = v0_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    sc_d    = sc_q;
    res_d   = res_q;
    m_w     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = opcode;
          typ_d   = op_type;
          sew_d   = vsew;
          vm_d    = vm;
          v0_d    = v0;
          vs1_d   = vs1;
          vs2_d   = vs2;
          sc_d    = (op_type == OP_VX) ? {{32{rs1[31]}}, rs1}
                                       : {{59{imm[4]}}, imm};
          ill_d   = ill_now;
          n_d     = n_now;
          g_d     = g_now;
          grp_d   = '0;
          res_d   = vd_old;
          state_d = (g_now == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < LANES; k++) begin
          if (en_l[k]) begin
            m_w   = VLEN'(wm) << sh_l[k];
            res_d = (res_d & ~m_w) | ((VLEN'(y_l[k]) << sh_l[k]) & m_w);
          end
        end
        grp_d = grp_q + VLW'(1);
        if (grp_q == g_q - VLW'(1)) begin
          grp_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      grp_q   <= '0;
      n_q     <= '0;
      g_q     <= '0;
      op_q    <= '0;
      typ_q   <= '0;
      sew_q   <= '0;
      vm_q    <= 1'b0;
      ill_q   <= 1'b0;
      v0_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      sc_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      n_q     <= n_d;
      g_q     <= g_d;
      op_q    <= op_d;
      typ_q   <= typ_d;
      sew_q   <= sew_d;
      vm_q    <= vm_d;
      ill_q   <= ill_d;
      v0_q    <= v0_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      sc_q    <= sc_d;
      res_q   <= res_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign illegal = ill_q;
  assign vd      = res_q;

endmodule

// File: tb/tb_rvv_lane_array.sv
// Bench for rvv_lane_array: directed cases plus random
// instructions against an element-level reference model.
module tb_rvv_lane_array;

  localparam int VLEN = 128;
  localparam int VLW  = 5;

  logic            clk = 1'b0;
  logic            resetn, start, vm;
  logic [5:0]      opcode;
  logic [2:0]      op_type, vsew;
  logic [VLW-1:0]  vl;
  logic [15:0]     v0;
  logic [VLEN-1:0] vs1, vs2, vd_old, vd;
  logic [31:0]     rs1;
  logic [4:0]      imm;
  logic            busy, done, illegal;

  int total = 0;
  int bad   = 0;

  rvv_lane_array #(.VLEN(VLEN), .LANES(2), .VLW(VLW)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .opcode  (opcode),
    .op_type (op_type),
    .vsew    (vsew),
    .vl      (vl),
    .vm      (vm),
    .v0      (v0),
    .vs1     (vs1),
    .vs2     (vs2),
    .vd_old  (vd_old),
    .rs1     (rs1),
    .imm     (imm),
    .busy    (busy),
    .done    (done),
    .illegal (illegal),
    .vd      (vd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [VLEN-1:0] got,
                     input logic [VLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [VLEN-1:0] put(input logic [VLEN-1:0] v,
                                          input int e, input int sewb,
                                          input logic [63:0] x);
    logic [VLEN-1:0] r;
    r = v;
    for (int j = 0; j < sewb; j++) r[e*sewb+j] = x[j];
    return r;
  endfunction

  function automatic logic [63:0] get(input logic [VLEN-1:0] v,
                                     input int e, input int sewb);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < sewb; j++) r[j] = v[e*sewb+j];
    return r;
  endfunction

  function automatic void model(
    input logic [5:0] op, input logic [2:0] typ, input logic [2:0] sew,
    input int vln, input bit vmv, input logic [15:0] v0v,
    input logic [VLEN-1:0] a_v, input logic [VLEN-1:0] b_v,
    input logic [VLEN-1:0] old, input logic [31:0] r1,
    input logic [4:0] im,
    output logic [VLEN-1:0] res, output bit ill, output int g);
    int sewb, n;
    logic [63:0] m, a, b, r;
    longint sa, sb;
    bit okop;
    okop = op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                      6'd9, 6'd10, 6'd11};
    ill = !okop || (sew > 3) || !(typ inside {3'b001, 3'b010, 3'b100})
          || (op == 6'd2 && typ == 3'b100)
          || (op == 6'd3 && typ == 3'b001);
    res = old;
    g = 0;
    if (ill) return;
    sewb = 8 << sew;
    n = (vln < VLEN / sewb) ? vln : VLEN / sewb;
    g = (n + 1) / 2;
    m = (sewb == 64) ? '1 : ((64'd1 << sewb) - 64'd1);
    for (int e = 0; e < n; e++) begin
      if (!(vmv || v0v[e])) continue;
      if (typ == 3'b001)      a = get(a_v, e, sewb);
      else if (typ == 3'b010) a = {{32{r1[31]}}, r1} & m;
      else                    a = {{59{im[4]}}, im} & m;
      b  = get(b_v, e, sewb);
      sa = longint'(a << (64 - sewb)) >>> (64 - sewb);
      sb = longint'(b << (64 - sewb)) >>> (64 - sewb);
      case (op)
        6'd0:    r = a + b;
        6'd2:    r = b - a;
        6'd3:    r = a - b;
        6'd4:    r = (a < b) ? a : b;
        6'd5:    r = (sa < sb) ? a : b;
        6'd6:    r = (a > b) ? a : b;
        6'd7:    r = (sa > sb) ? a : b;
        6'd9:    r = a & b;
        6'd10:   r = a | b;
        default: r = a ^ b;
      endcase
      res = put(res, e, sewb, r & m);
    end
  endfunction

  task automatic run(input string tag, input logic [5:0] op,
                     input logic [2:0] typ, input logic [2:0] sew,
                     input logic [4:0] vlv, input bit vmv,
                     input logic [15:0] v0v, input logic [VLEN-1:0] a_v,
                     input logic [VLEN-1:0] b_v,
                     input logic [VLEN-1:0] old, input logic [31:0] r1,
                     input logic [4:0] im, input logic [VLEN-1:0] exp,
                     input bit exp_ill, input int exp_g, input bit poke);
    int cyc;
    @(negedge clk);
    opcode = op; op_type = typ; vsew = sew; vl = vlv; vm = vmv;
    v0 = v0v; vs1 = a_v; vs2 = b_v; vd_old = old; rs1 = r1; imm = im;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (poke && cyc == 1) begin
        start = 1'b1; opcode = 6'd11; vs2 = ~b_v; vd_old = ~old; vl = 5'd1;
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, VLEN'(cyc), VLEN'(exp_g + 1));
    chk({tag, "_vd"}, vd, exp);
    chk({tag, "_ill"}, VLEN'(illegal), VLEN'(exp_ill));
    chk({tag, "_busy"}, VLEN'(busy), VLEN'(1));
    @(negedge clk);
    chk({tag, "_pulse"}, VLEN'({busy, done}), VLEN'(0));
    chk({tag, "_hold"}, vd, exp);
  endtask

  logic [VLEN-1:0] a_v, b_v, o_v, e_v;
  bit              e_ill;
  int              e_g;
  logic [5:0]      ops [10] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5,
                                6'd6, 6'd7, 6'd9, 6'd10, 6'd11};

  initial begin
    resetn = 1'b0; start = 1'b0; opcode = '0; op_type = 3'b001;
    vsew = '0; vl = '0; vm = 1'b1; v0 = '0; vs1 = '0; vs2 = '0;
    vd_old = '0; rs1 = '0; imm = '0;
    repeat (3) @(negedge clk);
    chk("rst_flags", VLEN'({busy, done, illegal}), VLEN'(0));
    chk("rst_vd", vd, '0);
    resetn = 1'b1;

    a_v = '0; b_v = '0; e_v = '0;
    for (int i = 0; i < 4; i++) begin
      a_v = put(a_v, i, 32, 64'(i + 1));
      b_v = put(b_v, i, 32, 64'(10 * (i + 1)));
      e_v = put(e_v, i, 32, 64'(11 * (i + 1)));
    end
    run("vadd_vv", 6'd0, 3'b001, 3'd2, 5'd4, 1'b1, '0, a_v, b_v, '0,
        '0, '0, e_v, 1'b0, 2, 1'b0);
    run("start_in_run", 6'd0, 3'b001, 3'd2, 5'd4, 1'b1, '0, a_v, b_v,
        '0, '0, '0, e_v, 1'b0, 2, 1'b1);

    o_v = {16{8'hAA}};
    e_v = o_v;
    for (int i = 0; i < 5; i++) e_v = put(e_v, i, 8, 64'hFF);
    run("vsub_vx", 6'd2, 3'b010, 3'd0, 5'd5, 1'b1, '0, '0, '0, o_v,
        32'd1, '0, e_v, 1'b0, 3, 1'b0);

    b_v = '0; o_v = '0; e_v = '0;
    for (int i = 0; i < 4; i++) begin
      b_v = put(b_v, i, 32, 64'd5);
      o_v = put(o_v, i, 32, 64'd9);
      e_v = put(e_v, i, 32, (i % 2 == 0) ? 64'd4 : 64'd9);
    end
    run("vadd_vi_mask", 6'd0, 3'b100, 3'd2, 5'd4, 1'b0, 16'b0101, '0,
        b_v, o_v, '0, 5'h1F, e_v, 1'b0, 2, 1'b0);

    a_v = {64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    b_v = {64'd2, 64'd0};
    run("vmin", 6'd5, 3'b001, 3'd3, 5'd2, 1'b1, '0, a_v, b_v, '0, '0,
        '0, {64'd1, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, 1, 1'b0);
    run("vminu", 6'd4, 3'b001, 3'd3, 5'd2, 1'b1, '0, a_v, b_v, '0, '0,
        '0, {64'd1, 64'd0}, 1'b0, 1, 1'b0);

    o_v = {$urandom, $urandom, $urandom, $urandom};
    run("vl_zero", 6'd0, 3'b001, 3'd0, 5'd0, 1'b1, '0, '1, '1, o_v,
        '0, '0, o_v, 1'b0, 0, 1'b0);
    run("illegal_op", 6'h3F, 3'b001, 3'd0, 5'd8, 1'b1, '0, '1, '1, o_v,
        '0, '0, o_v, 1'b1, 0, 1'b0);

    a_v = {$urandom, $urandom, $urandom, $urandom};
    b_v = {$urandom, $urandom, $urandom, $urandom};
    model(6'd0, 3'b001, 3'd0, 31, 1'b1, '0, a_v, b_v, o_v, '0, '0,
          e_v, e_ill, e_g);
    run("vl_clamp", 6'd0, 3'b001, 3'd0, 5'd31, 1'b1, '0, a_v, b_v, o_v,
        '0, '0, e_v, 1'b0, 8, 1'b0);

    @(negedge clk);
    opcode = 6'd0; op_type = 3'b001; vsew = 3'd0; vl = 5'd16; vm = 1'b1;
    vs1 = a_v; vs2 = b_v; vd_old = o_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_flags", VLEN'({busy, done}), VLEN'(0));
    chk("midrst_vd", vd, '0);
    resetn = 1'b1;
    run("after_rst", 6'd0, 3'b001, 3'd0, 5'd16, 1'b1, '0, a_v, b_v, o_v,
        '0, '0, e_v, 1'b0, 8, 1'b0);

    for (int t = 0; t < 60; t++) begin
      logic [5:0]  op;
      logic [2:0]  typ, sew;
      logic [4:0]  vlv;
      logic [15:0] v0v;
      logic [31:0] r1;
      logic [4:0]  im;
      bit          vmv;
      op  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      typ = ($urandom_range(0, 9) == 0) ? 3'($urandom)
                                        : 3'(1 << $urandom_range(0, 2));
      sew = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(4, 7))
                                         : 3'($urandom_range(0, 3));
      vlv = 5'($urandom);
      vmv = 1'($urandom);
      v0v = 16'($urandom);
      r1  = $urandom;
      im  = 5'($urandom);
      a_v = {$urandom, $urandom, $urandom, $urandom};
      b_v = {$urandom, $urandom, $urandom, $urandom};
      o_v = {$urandom, $urandom, $urandom, $urandom};
      model(op, typ, sew, int'(vlv), vmv, v0v, a_v, b_v, o_v, r1, im,
            e_v, e_ill, e_g);
      run($sformatf("rnd%0d", t), op, typ, sew, vlv, vmv, v0v, a_v, b_v,
          o_v, r1, im, e_v, e_ill, e_g, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
